// File: rtl/regfile_sb_if.sv
// Bundles the register-file read, write-back and issue signals.
// The master side is the pipeline; the slave side is regfile_sb.
interface regfile_sb_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
);
  localparam int AW = $clog2(NREGS);

  logic [AW-1:0]   addr_r1;
  logic [AW-1:0]   addr_r2;
  logic [XLEN-1:0] data_r1;
  logic [XLEN-1:0] data_r2;
  logic            busy_r1;
  logic            busy_r2;
  logic            we0;
  logic [AW-1:0]   addr_w0;
  logic [XLEN-1:0] data_w0;
  logic            we1;
  logic [AW-1:0]   addr_w1;
  logic [XLEN-1:0] data_w1;
  logic            iss_valid;
  logic [AW-1:0]   iss_rd;

  modport master (
    output addr_r1, addr_r2, we0, addr_w0, data_w0, we1, addr_w1, data_w1,
           iss_valid, iss_rd,
    input  data_r1, data_r2, busy_r1, busy_r2
  );

  modport slave (
    input  addr_r1, addr_r2, we0, addr_w0, data_w0, we1, addr_w1, data_w1,
           iss_valid, iss_rd,
    output data_r1, data_r2, busy_r1, busy_r2
  );
endinterface

// File: rtl/regfile_sb.sv
// NREGS x XLEN register file, two async reads, two write-back ports, busy-bit scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write-back data and busy clears to the reads.
module regfile_sb #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic         clk,
  input  logic         reset,
  regfile_sb_if.slave  rf
);
  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (rf.we0 && rf.addr_w0 != '0) regs_d[rf.addr_w0] = rf.data_w0;
    if (rf.we1 && rf.addr_w1 != '0) regs_d[rf.addr_w1] = rf.data_w1;
    // A new issue to r overrides a retiring write-back to r in the same cycle.
    for (int r = 1; r < NREGS; r++) begin
      if (rf.iss_valid && rf.iss_rd == AW'(r)) begin
        busy_d[r] = 1'b1;
      end else if ((rf.we0 && rf.addr_w0 == AW'(r)) ||
                   (rf.we1 && rf.addr_w1 == AW'(r))) begin
        busy_d[r] = 1'b0;
      end
    end
    regs_d[0] = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q <= '{default: '0};
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  // Returns {busy, data} for one read address.
  function automatic logic [XLEN:0] read_port(input logic [AW-1:0] a);
    logic [XLEN-1:0] d;
    logic            b;
    d = regs_q[a];
    b = busy_q[a];
`ifdef REGFILE_BYPASS_EN
    if (a != '0) begin
      if (rf.we1 && rf.addr_w1 == a) begin
        d = rf.data_w1;
        b = rf.iss_valid && rf.iss_rd == a;
      end else if (rf.we0 && rf.addr_w0 == a) begin
        d = rf.data_w0;
        b = rf.iss_valid && rf.iss_rd == a;
      end
    end
`endif
    return {b, d};
  endfunction

  logic [XLEN:0] rd1;
  logic [XLEN:0] rd2;

  always_comb begin
    rd1 = read_port(rf.addr_r1);
    rd2 = read_port(rf.addr_r2);
  end

  assign rf.data_r1 = rd1[XLEN-1:0];
  assign rf.busy_r1 = rd1[XLEN];
  assign rf.data_r2 = rd2[XLEN-1:0];
  assign rf.busy_r2 = rd2[XLEN];
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: stimulus queues expected read results, a negedge monitor checks them.
module tb_regfile_sb;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = $clog2(NREGS);

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk;
  logic reset;

  regfile_sb_if #(.XLEN(XLEN), .NREGS(NREGS)) rf ();

  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS)) dut (
    .clk   (clk),
    .reset (reset),
    .rf    (rf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0]   a1;
    logic [AW-1:0]   a2;
    logic [XLEN-1:0] d1;
    logic [XLEN-1:0] d2;
    logic            b1;
    logic            b2;
  } exp_t;

  exp_t exp_q[$];
  logic chk;
  int   checks;
  int   errors;

  task automatic cmp(input string name, input int addr, input logic [XLEN-1:0] got,
                     input logic [XLEN-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s addr=%0d got=%h want=%h", name, addr, got, want);
    end
  endtask

  // Monitor: compares the DUT read ports whenever a check is presented.
  always @(negedge clk) begin
    if (chk) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty got=0 want=1");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        cmp("data_r1", int'(e.a1), rf.data_r1, e.d1);
        cmp("data_r2", int'(e.a2), rf.data_r2, e.d2);
        cmp("busy_r1", int'(e.a1), XLEN'(rf.busy_r1), XLEN'(e.b1));
        cmp("busy_r2", int'(e.a2), XLEN'(rf.busy_r2), XLEN'(e.b2));
      end
    end
  end

  task automatic expect_rd(input int a1, input int a2, input logic [XLEN-1:0] d1,
                           input logic [XLEN-1:0] d2, input logic b1, input logic b2);
    exp_t e;
    e.a1 = AW'(a1);
    e.a2 = AW'(a2);
    e.d1 = d1;
    e.d2 = d2;
    e.b1 = b1;
    e.b2 = b2;
    rf.addr_r1 = AW'(a1);
    rf.addr_r2 = AW'(a2);
    exp_q.push_back(e);
    chk = 1'b1;
  endtask

  task automatic wr0(input int a, input logic [XLEN-1:0] d);
    rf.we0 = 1'b1; rf.addr_w0 = AW'(a); rf.data_w0 = d;
  endtask

  task automatic wr1(input int a, input logic [XLEN-1:0] d);
    rf.we1 = 1'b1; rf.addr_w1 = AW'(a); rf.data_w1 = d;
  endtask

  task automatic issue(input int a);
    rf.iss_valid = 1'b1; rf.iss_rd = AW'(a);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk = 1'b0;
    rf.we0 = 1'b0;
    rf.we1 = 1'b0;
    rf.iss_valid = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    chk = 1'b0;
    reset = 1'b1;
    rf.addr_r1 = '0; rf.addr_r2 = '0;
    rf.we0 = 1'b0; rf.addr_w0 = '0; rf.data_w0 = '0;
    rf.we1 = 1'b0; rf.addr_w1 = '0; rf.data_w1 = '0;
    rf.iss_valid = 1'b0; rf.iss_rd = '0;
    tick();
    tick();
    reset = 1'b0;

    for (int a = 0; a < NREGS; a++) begin
      expect_rd(a, NREGS - 1 - a, '0, '0, 1'b0, 1'b0);
      tick();
    end

    // Basic write, x0 hardwired
    wr0(5, 32'hDEADBEEF);
    tick();
    wr0(0, 32'h00001234);
    expect_rd(5, 0, 32'hDEADBEEF, '0, 1'b0, 1'b0);
    tick();
    expect_rd(0, 5, '0, 32'hDEADBEEF, 1'b0, 1'b0);
    tick();

    // Same-address dual write: port 1 wins
    wr0(7, 32'h11);
    wr1(7, 32'h22);
    tick();
    expect_rd(7, 7, 32'h22, 32'h22, 1'b0, 1'b0);
    tick();

    // Scoreboard set, clear, set-beats-clear
    issue(3);
    tick();
    expect_rd(3, 0, '0, '0, 1'b1, 1'b0);
    tick();
    wr1(3, 32'h33);
    tick();
    expect_rd(3, 3, 32'h33, 32'h33, 1'b0, 1'b0);
    tick();
    issue(3);
    wr0(3, 32'h44);
    tick();
    expect_rd(3, 0, 32'h44, '0, 1'b1, 1'b0);
    tick();
    issue(0);
    tick();
    expect_rd(0, 3, '0, 32'h44, 1'b0, 1'b1);
    tick();

    // Same-cycle write and read
    wr0(9, 32'hA5A5A5A5);
    expect_rd(0, 9, '0, BYP ? 32'hA5A5A5A5 : 32'h0, 1'b0, 1'b0);
    tick();
    expect_rd(0, 9, '0, 32'hA5A5A5A5, 1'b0, 1'b0);
    tick();

    // Same-cycle busy clear visibility
    issue(10);
    tick();
    wr1(10, 32'h55);
    expect_rd(10, 0, BYP ? 32'h55 : 32'h0, '0, !BYP, 1'b0);
    tick();
    expect_rd(10, 0, 32'h55, '0, 1'b0, 1'b0);
    tick();

    // Same-cycle write with reissue: busy stays set
    issue(11);
    tick();
    wr0(11, 32'h66);
    issue(11);
    expect_rd(11, 0, BYP ? 32'h66 : 32'h0, '0, 1'b1, 1'b0);
    tick();
    expect_rd(11, 0, 32'h66, '0, 1'b1, 1'b0);
    tick();

    // Same-cycle dual write forwarding priority
    wr0(12, 32'h1);
    wr1(12, 32'h2);
    expect_rd(12, 12, BYP ? 32'h2 : 32'h0, BYP ? 32'h2 : 32'h0, 1'b0, 1'b0);
    tick();

    // Reset overrides write and issue in the same cycle
    reset = 1'b1;
    wr0(4, 32'h77);
    issue(4);
    tick();
    reset = 1'b0;
    expect_rd(4, 5, '0, '0, 1'b0, 1'b0);
    tick();
    expect_rd(11, 3, '0, '0, 1'b0, 1'b0);
    tick();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised successor to the single-cycle core's register file, built for the pipelined core. Provides an NREGS x XLEN integer register file with two asynchronous read ports, two synchronous write-back ports, and an integrated busy-bit scoreboard. Issue logic marks a destination busy; write-back clears it; decode stalls on busy sources. Sits between decode/issue and the two write-back stages (ALU and load/long-latency).

## Interface

Parameters:
- XLEN, 32, register width in bits
- NREGS, 32, register count; power of two, 2..64; AW = $clog2(NREGS)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous active-high reset
- addr_r1  in  AW  read address, port 1
- addr_r2  in  AW  read address, port 2
- data_r1  out  XLEN  read data, port 1
- data_r2  out  XLEN  read data, port 2
- busy_r1  out  1  register addr_r1 has a pending write
- busy_r2  out  1  register addr_r2 has a pending write
- we0  in  1  write enable, write-back port 0 (ALU)
- addr_w0  in  AW  write address, port 0
- data_w0  in  XLEN  write data, port 0
- we1  in  1  write enable, write-back port 1 (load/long-latency)
- addr_w1  in  AW  write address, port 1
- data_w1  in  XLEN  write data, port 1
- iss_valid  in  1  instruction issued this cycle with a destination
- iss_rd  in  AW  destination of issued instruction

## Operation

- Register 0 hardwired: reads return 0, busy reads 0, writes and issue to it ignored.
- Write: on rising clk, weN && addr_wN != 0 stores data_wN. Both ports to the same address: port 1 wins.
- Scoreboard, one bit per register, next-state per register r != 0:
  - set if iss_valid && iss_rd == r
  - else clear if (we0 && addr_w0 == r) || (we1 && addr_w1 == r)
  - else hold
  - set beats clear in the same cycle (new producer issued while old one retires).
- Issuing to an already-busy register is legal; bit stays set, no counting (single outstanding producer per register is enforced upstream).
- Reset: all registers 0, all busy bits 0; reset overrides any write or issue in the same cycle.
- Reads are combinational on addr_rX and current state (plus bypass, see Configuration).

## Timing

- Read latency 0 cycles (combinational).
- Write/issue take effect at the rising edge where sampled; visible next cycle without bypass.
- After reset deasserts, every data_rX = 0 and busy_rX = 0.
- No handshake: we/iss_valid are single-cycle qualifiers, sampled every edge.

## Configuration

- REGFILE_BYPASS_EN defined: write-to-read forwarding. If weN && addr_wN == addr_rX && addr_rX != 0, data_rX returns data_wN in the same cycle (port 1 priority), and busy_rX reads 0 unless iss_valid && iss_rd == addr_rX in that cycle. Combinational path from write ports to read outputs.
- Undefined: data_rX and busy_rX reflect registered state only; written value and cleared busy appear the cycle after the write.

## Test plan

- Reset then read all addresses -> data_r1/data_r2 = 0, busy = 0 for all 0..NREGS-1.
- we0=1, addr_w0=5, data_w0=0xDEADBEEF; next cycle addr_r1=5 -> data_r1 = 0xDEADBEEF; write to x0 with 0x1234 -> read x0 = 0.
- Same cycle we0 (x7, 0x11) and we1 (x7, 0x22) -> x7 = 0x22.
- iss_valid, iss_rd=3 -> busy_r1(addr 3) = 1 next cycle; we1 to x3 -> busy 0 after edge; same cycle issue x3 and we0 to x3 -> busy stays 1, x3 holds written data.
- Write x9=0xA5A5A5A5 with addr_r2=9 same cycle -> data_r2 = 0xA5A5A5A5 and busy_r2 = 0 when REGFILE_BYPASS_EN defined; old value (0) until next cycle when undefined.
- Reset asserted in cycle with we0 to x4 and issue x4 -> x4 = 0, busy 0 afterwards.
